// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of mem_port_arbiter.
// The l_* members exist only when MPA_LOADER_PORT_EN is defined.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

`ifdef MPA_LOADER_PORT_EN
  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;
`endif

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Requesters and the memory macro side
  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
`ifdef MPA_LOADER_PORT_EN
    output l_req, l_we, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata,
`endif
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  // Arbiter side
  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
`ifdef MPA_LOADER_PORT_EN
    input  l_req, l_we, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata,
`endif
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin I/D arbiter for a single-port synchronous memory, with read-response routing
// and a saturating conflict counter. MPA_LOADER_PORT_EN adds a top-priority loader port.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic [CW-1:0]       conflict_cnt
);

  typedef enum logic { PORT_I, PORT_D } port_e;

`ifdef MPA_LOADER_PORT_EN
  typedef enum logic [1:0] { OWN_NONE, OWN_I, OWN_D, OWN_L } owner_e;
`else
  typedef enum logic [1:0] { OWN_NONE, OWN_I, OWN_D } owner_e;
`endif

  port_e         last;
  owner_e        owner;
  logic          i_gnt;
  logic          d_gnt;
  logic          l_gnt;
  logic [1:0]    n_req;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;
  logic          we_mux;

  // Grants are forced low while reset is asserted, not just registered state.
  always_comb begin
    l_gnt = 1'b0;
    i_gnt = 1'b0;
    d_gnt = 1'b0;
`ifdef MPA_LOADER_PORT_EN
    l_gnt = bus.l_req & rst;
`endif
    if (rst && !l_gnt) begin
      i_gnt = bus.i_req && (!bus.d_req || last == PORT_D);
      d_gnt = bus.d_req && (!bus.i_req || last == PORT_I);
    end
  end

  always_comb begin
    n_req = 2'(bus.i_req) + 2'(bus.d_req);
`ifdef MPA_LOADER_PORT_EN
    n_req = n_req + 2'(bus.l_req);
`endif
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    if (i_gnt) begin
      addr_mux = bus.i_addr;
    end else if (d_gnt) begin
      addr_mux  = bus.d_addr;
      wdata_mux = bus.d_wdata;
      we_mux    = bus.d_we;
    end
`ifdef MPA_LOADER_PORT_EN
    if (l_gnt) begin
      addr_mux  = bus.l_addr;
      wdata_mux = bus.l_wdata;
      we_mux    = bus.l_we;
    end
`endif
  end

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = i_gnt | d_gnt | l_gnt;
  assign bus.mem_we    = we_mux;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last         <= PORT_D;
      owner        <= OWN_NONE;
      conflict_cnt <= '0;
    end else begin
      // A loader grant leaves the I/D fairness pointer untouched.
      if (i_gnt)      last <= PORT_I;
      else if (d_gnt) last <= PORT_D;

      owner <= OWN_NONE;
      if (i_gnt)                     owner <= OWN_I;
      else if (d_gnt && !bus.d_we)   owner <= OWN_D;
`ifdef MPA_LOADER_PORT_EN
      if (l_gnt) owner <= bus.l_we ? OWN_NONE : OWN_L;
`endif

      if (n_req >= 2'd2 && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  always_comb begin
    bus.i_rvalid = (owner == OWN_I);
    bus.d_rvalid = (owner == OWN_D);
    bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
    bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;
`ifdef MPA_LOADER_PORT_EN
    bus.l_rvalid = (owner == OWN_L);
    bus.l_rdata  = bus.l_rvalid ? bus.mem_rdata : '0;
`endif
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps plus randomized traffic
// checked cycle by cycle against a rule-level reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Reference state: which of I/D was granted last, who owns the next response, conflict count
  bit m_last_d;
  int m_owner;   // 0 none, 1 I, 2 D, 3 L
  int m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
`ifdef MPA_LOADER_PORT_EN
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
`endif
  endtask

  // Called just after a falling edge with inputs set; checks, advances the model, returns at next falling edge.
  task automatic cyc(input logic [DW-1:0] rd);
    bit lq, iq, dq, eg_l, eg_i, eg_d, ewe, lwe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    int nreq;
    bus.mem_rdata = rd;
    if (!rst) begin
      m_last_d = 1'b1; m_owner = 0; m_cnt = 0;
    end
    #1;
    lq = 1'b0; lwe = 1'b0;
`ifdef MPA_LOADER_PORT_EN
    lq = bus.l_req; lwe = bus.l_we;
`endif
    iq = bus.i_req; dq = bus.d_req;
    eg_l = rst && lq;
    eg_i = 1'b0; eg_d = 1'b0;
    if (rst && !lq) begin
      if (iq && dq) begin eg_i = m_last_d; eg_d = !m_last_d; end
      else begin eg_i = iq; eg_d = dq; end
    end
    ea = '0; ew = '0; ewe = 1'b0;
    if (eg_i) ea = bus.i_addr;
    if (eg_d) begin ea = bus.d_addr; ew = bus.d_wdata; ewe = bus.d_we; end
`ifdef MPA_LOADER_PORT_EN
    if (eg_l) begin ea = bus.l_addr; ew = bus.l_wdata; ewe = bus.l_we; end
`endif
    check("i_gnt", bus.i_gnt, eg_i);
    check("d_gnt", bus.d_gnt, eg_d);
    check("mem_en", bus.mem_en, eg_i | eg_d | eg_l);
    check("mem_we", bus.mem_we, ewe);
    check("mem_addr", bus.mem_addr, ea);
    check("mem_wdata", bus.mem_wdata, ew);
    check("i_rvalid", bus.i_rvalid, m_owner == 1);
    check("i_rdata", bus.i_rdata, (m_owner == 1) ? rd : '0);
    check("d_rvalid", bus.d_rvalid, m_owner == 2);
    check("d_rdata", bus.d_rdata, (m_owner == 2) ? rd : '0);
`ifdef MPA_LOADER_PORT_EN
    check("l_gnt", bus.l_gnt, eg_l);
    check("l_rvalid", bus.l_rvalid, m_owner == 3);
    check("l_rdata", bus.l_rdata, (m_owner == 3) ? rd : '0);
`endif
    check("conflict_cnt", conflict_cnt, m_cnt);
    if (rst) begin
      nreq = int'(iq) + int'(dq) + int'(lq);
      if (nreq >= 2 && m_cnt < CMAX) m_cnt++;
      if (eg_i) m_last_d = 1'b0;
      if (eg_d) m_last_d = 1'b1;
      if (eg_l)                  m_owner = lwe ? 0 : 3;
      else if (eg_i)             m_owner = 1;
      else if (eg_d && !bus.d_we) m_owner = 2;
      else                       m_owner = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    cyc($urandom);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    bus.mem_rdata = '0;
    m_last_d = 1'b1; m_owner = 0; m_cnt = 0;
    @(negedge clk);

    // Reset with every request held high
    bus.i_req = 1'b1; bus.d_req = 1'b1;
`ifdef MPA_LOADER_PORT_EN
    bus.l_req = 1'b1;
`endif
    cyc($urandom);
    cyc($urandom);
    rst = 1'b1;
`ifdef MPA_LOADER_PORT_EN
    bus.l_req = 1'b0;
`endif
    cyc($urandom);            // first cycle after release: I wins
    idle();
    cyc($urandom);

    // Uncontested read
    do_reset();
    bus.d_req = 1'b1; bus.d_addr = 32'h10;
    cyc($urandom);
    idle();
    cyc(32'hDEADBEEF);

    // Sustained contest, then the counter must read 6
    do_reset();
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    bus.i_addr = 32'h100; bus.d_addr = 32'h200;
    for (int k = 0; k < 6; k++) cyc($urandom);
    idle();
    cyc($urandom);
    check("contest_cnt6", conflict_cnt, 6);

    // Write produces no response
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h5;
    cyc($urandom);
    idle();
    cyc($urandom);

`ifdef MPA_LOADER_PORT_EN
    // Loader overrides I/D, then I/D resolves with the pre-loader pointer
    bus.l_req = 1'b1; bus.l_addr = 32'h40; bus.i_req = 1'b1; bus.d_req = 1'b1;
    for (int k = 0; k < 3; k++) cyc($urandom);
    bus.l_req = 1'b0;
    cyc($urandom);
    cyc($urandom);
    idle();
    cyc($urandom);
`endif

    // Saturation after 20 conflicting cycles
    do_reset();
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    for (int k = 0; k < 20; k++) cyc($urandom);
    idle();
    cyc($urandom);
    check("sat_cnt", conflict_cnt, CMAX);

    // Reset asserted the cycle after a read grant discards the response
    bus.d_req = 1'b1; bus.d_addr = 32'h30;
    cyc($urandom);
    idle();
    rst = 1'b0;
    cyc($urandom);
    rst = 1'b1;
    cyc($urandom);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(63) != 0);
      bus.i_req = $urandom_range(1); bus.i_addr = {$urandom_range(255), 2'b00};
      bus.d_req = $urandom_range(1); bus.d_we = $urandom_range(1);
      bus.d_addr = {$urandom_range(255), 2'b00}; bus.d_wdata = $urandom;
`ifdef MPA_LOADER_PORT_EN
      bus.l_req = ($urandom_range(3) == 0); bus.l_we = $urandom_range(1);
      bus.l_addr = {$urandom_range(255), 2'b00}; bus.l_wdata = $urandom;
`endif
      cyc($urandom);
    end
    rst = 1'b1;
    idle();
    cyc($urandom);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
